// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame geometry, FSM state encoding and
// the odd-parity check used when a frame's stop bit arrives.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] byte_i, input logic par_i);
    return ^{byte_i, par_i};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO: head is combinational, push/pop land on the next edge (1 cycle).
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot on the same edge, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/ps2_rx_buffered.sv
// PS/2 device-to-host receiver feeding a show-ahead byte FIFO; a byte is visible the cycle after its stop edge.
// Consumer backpressure is ready; frames arriving while the FIFO is full and not popped are dropped and flagged.
module ps2_rx_buffered
  import ps2_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 50000,
  parameter int DROP_BAD = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  input  logic                   ready,
  input  logic                   err_clr,
  output logic [7:0]             data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   parity_err,
  output logic                   stop_err,
  output logic                   timeout_err,
  output logic                   overflow
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]           clk_sync_q;
  logic [1:0]           dat_sync_q;
  logic                 clk_prev_q;
  logic                 fall;
  logic                 sample;

  ps2_state_e           state_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [TW-1:0]        tmo_q;
  logic                 parity_err_q;
  logic                 stop_err_q;
  logic                 timeout_err_q;
  logic                 overflow_q;

  logic                 at_stop;
  logic                 par_bad;
  logic                 stop_bad;
  logic                 tmo_hit;
  logic                 frame_push;
  logic                 fifo_pop;
  logic                 ovf_evt;

  // Synchronisers idle high so leaving reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fall   = !clk_sync_q[1] && clk_prev_q;
  assign sample = dat_sync_q[1];

  assign at_stop    = fall && (state_q == STOP);
  assign par_bad    = !odd_parity_ok(shift_q, parity_q);
  assign stop_bad   = !sample;
  assign tmo_hit    = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT - 1));
  assign frame_push = at_stop && ((!par_bad && !stop_bad) || (DROP_BAD == 0));
  assign fifo_pop   = valid && ready;
  assign ovf_evt    = frame_push && full && !fifo_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      tmo_q         <= '0;
      parity_err_q  <= 1'b0;
      stop_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if ((state_q == IDLE) || fall || tmo_hit) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (tmo_hit) begin
        state_q <= IDLE;
      end else if (fall) begin
        unique case (state_q)
          IDLE: begin
            if (!sample) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {sample, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'(DATA_BITS - 1)) state_q <= PARITY;
          end
          PARITY: begin
            parity_q <= sample;
            state_q  <= STOP;
          end
          STOP:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end

      // A new error event wins over a same-cycle clear.
      parity_err_q  <= (at_stop && par_bad)  || (parity_err_q  && !err_clr);
      stop_err_q    <= (at_stop && stop_bad) || (stop_err_q    && !err_clr);
      timeout_err_q <= tmo_hit               || (timeout_err_q && !err_clr);
      overflow_q    <= ovf_evt               || (overflow_q    && !err_clr);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (frame_push),
    .push_dat (shift_q),
    .pop      (fifo_pop),
    .head_dat (data),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign valid       = !empty;
  assign parity_err  = parity_err_q;
  assign stop_err    = stop_err_q;
  assign timeout_err = timeout_err_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/ps2_rx_buffered.md
PS2_RX_BUFFERED -- requirements
Module: ps2_rx_buffered

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries; a power of two, at least 2.
REQ-002 SHALL have parameter TIMEOUT, default 50000: clk cycles without a ps2_clk falling edge that abort a partial frame.
REQ-003 SHALL have parameter DROP_BAD, default 1: 1 discards frames with errors; 0 stores them anyway.
REQ-004 SHALL have a single clock and an asynchronous, active-low reset, ports as follows.
REQ-005 clk  input  1  system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-008 ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-009 ready  input  1  consumer accepts the head byte.
REQ-010 err_clr  input  1  one-cycle pulse that clears all sticky error flags.
REQ-011 data  output  8  FIFO head byte (show-ahead).
REQ-012 valid  output  1  FIFO not empty.
REQ-013 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 empty, full  output  1 each  FIFO status.
REQ-015 parity_err, stop_err, timeout_err, overflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers; a falling edge is a cycle where the synchronised clock is 0 and its previous value was 1.
REQ-017 SHALL sample the synchronised ps2_data only on a detected falling edge.
REQ-018 SHALL use FSM states IDLE, DATA, PARITY, STOP.
- IDLE: sample 0 -> DATA with bit index 0; sample 1 -> remain in IDLE, no error raised.
- DATA: shift the sample in LSB first; after the 8th bit -> PARITY.
- PARITY: store the sample -> STOP.
- STOP: evaluate the frame -> IDLE.
REQ-019 Parity is odd: parity is good when the number of ones across the data byte and the parity bit is odd.
REQ-020 On the STOP edge, a bad parity SHALL set parity_err and a sample of 0 SHALL set stop_err.
REQ-021 On the STOP edge, the byte SHALL be pushed when both parity and stop are good, or whenever DROP_BAD=0.
REQ-022 A pushed byte SHALL appear on data/valid in the cycle after the STOP edge is detected.
REQ-023 Outside IDLE, a timeout counter SHALL clear on every falling edge and increment otherwise.
REQ-024 When the timeout counter reaches TIMEOUT-1, the FSM SHALL return to IDLE and set timeout_err; the partial byte is never pushed.
REQ-025 A pop SHALL occur when valid && ready; it takes effect on the next clock edge.
REQ-026 A push while full with no pop SHALL drop the byte, set overflow and leave the FIFO contents unchanged.
REQ-027 A simultaneous push and pop while full SHALL accept both; count stays at DEPTH.
REQ-028 A simultaneous push and pop while empty SHALL perform only the push; valid is 0 in that cycle, so no pop occurs.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 count SHALL equal the number of pushes minus the number of pops, in the range 0..DEPTH.
REQ-031 err_clr SHALL clear all four error flags; an error event in the same cycle takes priority and leaves its flag set.

Reset
REQ-032 While rst_n=0, the following SHALL hold immediately:
- FSM in IDLE; pointers, count and timeout counter at 0.
- valid=0, empty=1, full=0, data=8'h00, all error flags 0.
- synchroniser flops at 1 (bus idle).
REQ-033 A reset mid-frame SHALL abort the frame; bits already received SHALL never be pushed.

Structure
REQ-034 Shared package ps2_pkg SHALL hold the FSM state enum and frame constants: FRAME_BITS=11, DATA_BITS=8.
REQ-035 The FIFO SHALL be a sub-module named sync_fifo, parametrised by WIDTH and DEPTH, with push, pop, full, empty and count.

Verification
REQ-036 Frame 0x1C with parity 0, stop 1, ready=0 -> data=8'h1C, valid=1, count=1, no error flags.
REQ-037 Frame 0x1C with parity 1, DROP_BAD=1 -> parity_err=1, count unchanged; with DROP_BAD=0 -> byte 0x1C is pushed and parity_err=1.
REQ-038 DEPTH=4, ready=0, frames 0x01..0x05 -> full=1, overflow=1; then ready=1 pops 0x01..0x04 in order, followed by empty=1.
REQ-039 Four bits sent, then ps2_clk held high -> timeout_err=1 after TIMEOUT cycles; the next frame 0x5A is received correctly.
REQ-040 rst_n pulsed low after the 5th bit of a frame, then frame 0x29 sent -> only 0x29 is present, count=1.
REQ-041 FIFO full with ready=1 held while a frame completes -> count remains DEPTH, the new byte is at the tail, overflow=0.
